// File: rtl/reg_file_pkg.sv
// Shared constants, select type and range helper for the multi-port register file.
package reg_file_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int NUM_REGS_DEF = 16;
   localparam int ADDR_W_DEF   = 5;

   typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

   function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_regs);
      return sel < num_regs;
   endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Read, write and issue signals of the register file; master drives selects/writes, slave returns data.
interface reg_file_mp_if
   import reg_file_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   logic [ADDR_W-1:0] rd_sel_a, rd_sel_b, rd_sel_c;
   logic [DATA_W-1:0] rd_data_a, rd_data_b, rd_data_c;
   logic              rd_busy_a, rd_busy_b, rd_busy_c;
   logic              we0, we1;
   logic [ADDR_W-1:0] wsel0, wsel1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_sel;
   logic              any_busy;

   modport master (
      output rd_sel_a, rd_sel_b, rd_sel_c,
      output we0, wsel0, wdata0, we1, wsel1, wdata1,
      output issue_valid, issue_sel,
      input  rd_data_a, rd_data_b, rd_data_c,
      input  rd_busy_a, rd_busy_b, rd_busy_c,
      input  any_busy
   );

   modport slave (
      input  rd_sel_a, rd_sel_b, rd_sel_c,
      input  we0, wsel0, wdata0, we1, wsel1, wdata1,
      input  issue_valid, issue_sel,
      output rd_data_a, rd_data_b, rd_data_c,
      output rd_busy_a, rd_busy_b, rd_busy_c,
      output any_busy
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: issue marks a register pending, a write on either port retires it.
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_sel,
   input  logic              we0,
   input  logic [ADDR_W-1:0] wsel0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] wsel1,
   input  logic [ADDR_W-1:0] look_sel_a,
   input  logic [ADDR_W-1:0] look_sel_b,
   input  logic [ADDR_W-1:0] look_sel_c,
   output logic              look_busy_a,
   output logic              look_busy_b,
   output logic              look_busy_c,
   output logic              any_busy
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   // Issue is applied last so a new producer outranks a retiring one.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (we0 && wsel0 == ADDR_W'(i)) busy_d[i] = 1'b0;
         if (we1 && wsel1 == ADDR_W'(i)) busy_d[i] = 1'b0;
         if (issue_valid && issue_sel == ADDR_W'(i)) busy_d[i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   always_comb begin
      look_busy_a = 1'b0;
      look_busy_b = 1'b0;
      look_busy_c = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (look_sel_a == ADDR_W'(i)) look_busy_a = busy_q[i];
         if (look_sel_b == ADDR_W'(i)) look_busy_b = busy_q[i];
         if (look_sel_c == ADDR_W'(i)) look_busy_c = busy_q[i];
      end
   end

   assign any_busy = |busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Three-read / two-write register file with busy scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle writes to the read ports.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input  logic         clk,
   input  logic         reset,
   reg_file_mp_if.slave rf
);

   logic [DATA_W-1:0] mem_q [NUM_REGS];
   logic [DATA_W-1:0] mem_d [NUM_REGS];
   logic [ADDR_W-1:0] rd_sel  [3];
   logic [DATA_W-1:0] rd_data [3];
   logic              rd_busy [3];
   logic              sb_busy [3];

   // Out-of-range write selects match no entry, so they vanish without aliasing.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         mem_d[i] = mem_q[i];
         if (rf.we0 && rf.wsel0 == ADDR_W'(i)) mem_d[i] = rf.wdata0;
         if (rf.we1 && rf.wsel1 == ADDR_W'(i)) mem_d[i] = rf.wdata1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   reg_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_scoreboard (
      .clk         (clk),
      .reset       (reset),
      .issue_valid (rf.issue_valid),
      .issue_sel   (rf.issue_sel),
      .we0         (rf.we0),
      .wsel0       (rf.wsel0),
      .we1         (rf.we1),
      .wsel1       (rf.wsel1),
      .look_sel_a  (rd_sel[0]),
      .look_sel_b  (rd_sel[1]),
      .look_sel_c  (rd_sel[2]),
      .look_busy_a (sb_busy[0]),
      .look_busy_b (sb_busy[1]),
      .look_busy_c (sb_busy[2]),
      .any_busy    (rf.any_busy)
   );

   assign rd_sel[0] = rf.rd_sel_a;
   assign rd_sel[1] = rf.rd_sel_b;
   assign rd_sel[2] = rf.rd_sel_c;

`ifdef REG_FILE_BYPASS_EN
   logic [2:0] fwd;

   always_comb begin
      fwd = '0;
      for (int p = 0; p < 3; p++) begin
         rd_data[p] = '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_sel[p] == ADDR_W'(i)) rd_data[p] = mem_q[i];
         end
         if (reset && sel_in_range(32'(rd_sel[p]), NUM_REGS)) begin
            if (rf.we0 && rf.wsel0 == rd_sel[p]) begin
               rd_data[p] = rf.wdata0;
               fwd[p]     = 1'b1;
            end
            if (rf.we1 && rf.wsel1 == rd_sel[p]) begin
               rd_data[p] = rf.wdata1;
               fwd[p]     = 1'b1;
            end
         end
         // Forwarded data is final unless a new producer claims the register this cycle.
         rd_busy[p] = sb_busy[p] & ~(fwd[p] & ~(rf.issue_valid && rf.issue_sel == rd_sel[p]));
      end
   end
`else
   always_comb begin
      for (int p = 0; p < 3; p++) begin
         rd_data[p] = '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_sel[p] == ADDR_W'(i)) rd_data[p] = mem_q[i];
         end
         rd_busy[p] = sb_busy[p];
      end
   end
`endif

   assign rf.rd_data_a = rd_data[0];
   assign rf.rd_data_b = rd_data[1];
   assign rf.rd_data_c = rd_data[2];
   assign rf.rd_busy_a = rd_busy[0];
   assign rf.rd_busy_b = rd_busy[1];
   assign rf.rd_busy_c = rd_busy[2];

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp (12-register build): directed vector table, bypass sequence, random vs array model.
module tb_reg_file_mp;
   localparam int NR = 12;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   reg_file_mp_if #(.DATA_W(32), .ADDR_W(5)) rf_if ();

   reg_file_mp #(.DATA_W(32), .NUM_REGS(NR), .ADDR_W(5)) dut (
      .clk   (clk),
      .reset (rst_n),
      .rf    (rf_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // stimulus mirror
   bit          t_rst_n, t_we0, t_we1, t_iv;
   logic [4:0]  t_ws0, t_ws1, t_is, t_sa, t_sb, t_sc;
   logic [31:0] t_wd0, t_wd1;

   // reference model
   logic [31:0] m_mem  [NR];
   bit          m_busy [NR];

   typedef struct {
      bit          rst_n;
      bit          we0;
      logic [4:0]  ws0;
      logic [31:0] wd0;
      bit          we1;
      logic [4:0]  ws1;
      logic [31:0] wd1;
      bit          iv;
      logic [4:0]  isel;
      logic [4:0]  chk_sel;
      logic [31:0] exp_data;
      bit          exp_busy;
      bit          exp_any;
   } vec_t;

   vec_t tbl [16];

   function automatic vec_t mk(bit r, bit w0, int s0, logic [31:0] d0, bit w1, int s1, logic [31:0] d1,
                               bit iv, int isel, int cs, logic [31:0] ed, bit eb, bit ea);
      vec_t v;
      v.rst_n = r; v.we0 = w0; v.ws0 = 5'(s0); v.wd0 = d0;
      v.we1 = w1; v.ws1 = 5'(s1); v.wd1 = d1; v.iv = iv; v.isel = 5'(isel);
      v.chk_sel = 5'(cs); v.exp_data = ed; v.exp_busy = eb; v.exp_any = ea;
      return v;
   endfunction

   task automatic push();
      rst_n          = t_rst_n;
      rf_if.we0      = t_we0;  rf_if.wsel0 = t_ws0; rf_if.wdata0 = t_wd0;
      rf_if.we1      = t_we1;  rf_if.wsel1 = t_ws1; rf_if.wdata1 = t_wd1;
      rf_if.issue_valid = t_iv; rf_if.issue_sel = t_is;
      rf_if.rd_sel_a = t_sa; rf_if.rd_sel_b = t_sb; rf_if.rd_sel_c = t_sc;
   endtask

   task automatic idle(bit r);
      t_rst_n = r; t_we0 = 0; t_we1 = 0; t_iv = 0;
      t_ws0 = 0; t_ws1 = 0; t_is = 0; t_wd0 = 0; t_wd1 = 0;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_data(logic [4:0] sel);
      logic [31:0] d;
      if (int'(sel) >= NR) return 32'h0;
      d = m_mem[sel];
`ifdef REG_FILE_BYPASS_EN
      if (t_rst_n) begin
         if (t_we0 && t_ws0 == sel) d = t_wd0;
         if (t_we1 && t_ws1 == sel) d = t_wd1;
      end
`endif
      return d;
   endfunction

   function automatic bit exp_busy(logic [4:0] sel);
      bit b;
      if (int'(sel) >= NR) return 1'b0;
      b = m_busy[sel];
`ifdef REG_FILE_BYPASS_EN
      if (t_rst_n && ((t_we0 && t_ws0 == sel) || (t_we1 && t_ws1 == sel)) && !(t_iv && t_is == sel))
         b = 1'b0;
`endif
      return b;
   endfunction

   function automatic bit exp_any();
      bit a = 0;
      for (int i = 0; i < NR; i++) a |= m_busy[i];
      return a;
   endfunction

   task automatic model_edge();
      if (!t_rst_n) begin
         for (int i = 0; i < NR; i++) begin m_mem[i] = 0; m_busy[i] = 0; end
      end else begin
         if (t_we0 && int'(t_ws0) < NR) begin m_mem[t_ws0] = t_wd0; m_busy[t_ws0] = 0; end
         if (t_we1 && int'(t_ws1) < NR) begin m_mem[t_ws1] = t_wd1; m_busy[t_ws1] = 0; end
         if (t_iv && int'(t_is) < NR) m_busy[t_is] = 1;
      end
   endtask

   task automatic check_model();
      chk("data_a", rf_if.rd_data_a, exp_data(t_sa));
      chk("data_b", rf_if.rd_data_b, exp_data(t_sb));
      chk("data_c", rf_if.rd_data_c, exp_data(t_sc));
      chk("busy_a", 32'(rf_if.rd_busy_a), 32'(exp_busy(t_sa)));
      chk("busy_b", 32'(rf_if.rd_busy_b), 32'(exp_busy(t_sb)));
      chk("busy_c", 32'(rf_if.rd_busy_c), 32'(exp_busy(t_sc)));
      chk("any_busy", 32'(rf_if.any_busy), 32'(exp_any()));
   endtask

   // inputs are set at posedge+1; outputs sampled at posedge+2
   task automatic cycle();
      push();
      #1;
      check_model();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      tbl[0]  = mk(0, 0, 0, 0,            0, 0,  0,     0, 0,  0,  0,            0, 0);
      tbl[1]  = mk(0, 0, 0, 0,            0, 0,  0,     0, 0,  3,  0,            0, 0);
      tbl[2]  = mk(1, 1, 3, 32'hDEADBEEF, 0, 0,  0,     0, 0,  3,  32'hDEADBEEF, 0, 0);
      tbl[3]  = mk(1, 1, 5, 32'h11,       1, 5,  32'h22, 0, 0, 5,  32'h22,       0, 0);
      tbl[4]  = mk(1, 1, 6, 32'h33,       1, 7,  32'h44, 0, 0, 6,  32'h33,       0, 0);
      tbl[5]  = mk(1, 0, 0, 0,            0, 0,  0,     0, 0,  7,  32'h44,       0, 0);
      tbl[6]  = mk(1, 0, 0, 0,            0, 0,  0,     1, 4,  4,  0,            1, 1);
      tbl[7]  = mk(1, 0, 0, 0,            1, 4,  32'hAB, 0, 0, 4,  32'hAB,       0, 0);
      tbl[8]  = mk(1, 1, 4, 32'hCD,       0, 0,  0,     1, 4,  4,  32'hCD,       1, 1);
      tbl[9]  = mk(1, 0, 0, 0,            1, 4,  32'h1, 0, 0,  4,  32'h1,        0, 0);
      tbl[10] = mk(1, 1, 13, 32'h55,      0, 0,  0,     0, 0,  13, 0,            0, 0);
      tbl[11] = mk(1, 0, 0, 0,            1, 1,  32'h5A, 0, 0, 1,  32'h5A,       0, 0);
      tbl[12] = mk(1, 1, 13, 32'h55,      0, 0,  0,     0, 0,  1,  32'h5A,       0, 0);
      tbl[13] = mk(1, 0, 0, 0,            0, 0,  0,     1, 14, 14, 0,            0, 0);
      tbl[14] = mk(1, 1, 2, 32'h99,       0, 0,  0,     1, 2,  2,  32'h99,       1, 1);
      tbl[15] = mk(0, 1, 2, 32'h77,       0, 0,  0,     1, 2,  2,  0,            0, 0);

      idle(0);
      t_sa = 0; t_sb = 0; t_sc = 0;
      push();
      repeat (2) @(posedge clk);
      for (int i = 0; i < NR; i++) begin m_mem[i] = 0; m_busy[i] = 0; end
      #1;

      foreach (tbl[k]) begin
         t_rst_n = tbl[k].rst_n;
         t_we0 = tbl[k].we0; t_ws0 = tbl[k].ws0; t_wd0 = tbl[k].wd0;
         t_we1 = tbl[k].we1; t_ws1 = tbl[k].ws1; t_wd1 = tbl[k].wd1;
         t_iv = tbl[k].iv;   t_is = tbl[k].isel;
         t_sa = 5'($urandom_range(0, 15)); t_sb = 5'($urandom_range(0, 15)); t_sc = 5'($urandom_range(0, 15));
         cycle();
         idle(tbl[k].rst_n);
         t_sa = tbl[k].chk_sel;
         push();
         #1;
         chk($sformatf("vec%0d_data", k), rf_if.rd_data_a, tbl[k].exp_data);
         chk($sformatf("vec%0d_busy", k), 32'(rf_if.rd_busy_a), 32'(tbl[k].exp_busy));
         chk($sformatf("vec%0d_any", k), 32'(rf_if.any_busy), 32'(tbl[k].exp_any));
         @(posedge clk);
         model_edge();
         #1;
      end

      // bypass: R8 holds 0x1234 and is busy, then port 1 writes 0xCAFE while port b reads R8
      idle(1); t_sb = 8; t_we0 = 1; t_ws0 = 8; t_wd0 = 32'h1234;
      cycle();
      idle(1); t_iv = 1; t_is = 8;
      cycle();
      idle(1); t_we1 = 1; t_ws1 = 8; t_wd1 = 32'hCAFE;
      push();
      #1;
`ifdef REG_FILE_BYPASS_EN
      chk("bypass_same_cycle_data", rf_if.rd_data_b, 32'hCAFE);
      chk("bypass_same_cycle_busy", 32'(rf_if.rd_busy_b), 32'h0);
`else
      chk("nobypass_same_cycle_data", rf_if.rd_data_b, 32'h1234);
      chk("nobypass_same_cycle_busy", 32'(rf_if.rd_busy_b), 32'h1);
`endif
      @(posedge clk);
      model_edge();
      #1;
      idle(1);
      push();
      #1;
      chk("bypass_next_cycle_data", rf_if.rd_data_b, 32'hCAFE);
      chk("bypass_next_cycle_busy", 32'(rf_if.rd_busy_b), 32'h0);
      // forwarding is suppressed during reset
      idle(0); t_we1 = 1; t_ws1 = 8; t_wd1 = 32'hBEEF;
      push();
      #1;
      chk("reset_no_forward", rf_if.rd_data_b, 32'hCAFE);
      @(posedge clk);
      model_edge();
      #1;

      for (int n = 0; n < 1500; n++) begin
         t_rst_n = ($urandom_range(0, 39) != 0);
         t_we0 = 1'($urandom); t_ws0 = 5'($urandom_range(0, 15)); t_wd0 = $urandom;
         t_we1 = 1'($urandom); t_ws1 = ($urandom_range(0, 3) == 0) ? t_ws0 : 5'($urandom_range(0, 15));
         t_wd1 = $urandom;
         t_iv = ($urandom_range(0, 2) == 0);
         t_is = ($urandom_range(0, 3) == 0) ? t_ws1 : 5'($urandom_range(0, 15));
         t_sa = ($urandom_range(0, 2) == 0) ? t_ws0 : 5'($urandom_range(0, 15));
         t_sb = ($urandom_range(0, 2) == 0) ? t_ws1 : 5'($urandom_range(0, 15));
         t_sc = 5'($urandom_range(0, 15));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the ARM32 core datapath.
- 3 asynchronous read ports (Rn, Rm, Rs), 2 synchronous write ports (ALU writeback, load/base writeback).
- Integrated busy-bit scoreboard for pipeline hazard detection.
- Replaces the single-write, two-read register file in the decode/writeback stages.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 16, number of architectural registers (2..32).
- ADDR_W, 5, select width; must satisfy 2**ADDR_W >= NUM_REGS.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-low. Registers are cleared on a clk edge while reset=0.
- rd_sel_a / rd_sel_b / rd_sel_c  in  ADDR_W each  read selects.
- rd_data_a / rd_data_b / rd_data_c  out  DATA_W each  read data.
- rd_busy_a / rd_busy_b / rd_busy_c  out  1 each  scoreboard busy bit of the selected register.
- we0  in  1  write enable, port 0.
- wsel0  in  ADDR_W  write select, port 0.
- wdata0  in  DATA_W  write data, port 0.
- we1 / wsel1 / wdata1: same as port 0, for port 1.
- issue_valid  in  1  marks a register as pending-write.
- issue_sel  in  ADDR_W  register being marked.
- any_busy  out  1  OR of all busy bits.

Behaviour:
- Storage: NUM_REGS x DATA_W flops, plus a NUM_REGS-bit busy vector.
- Reset: on a clk edge with reset=0, all registers and all busy bits go to 0. Writes and issues in that cycle are ignored.
  - After reset, every rd_data_* = 0, every rd_busy_* = 0, any_busy = 0.
- Reads: combinational, 0-cycle latency from rd_sel_* to rd_data_* and rd_busy_*.
  - Any select >= NUM_REGS reads data 0 and busy 0.
- Writes: take effect at the clk edge while reset=1. New value is visible to reads the cycle after.
  - A write with select >= NUM_REGS is ignored; no aliasing.
  - we0 and we1 to the same register in the same cycle: port 1 wins.
- Scoreboard:
  - issue_valid sets busy[issue_sel] at the clk edge.
  - A write on either port clears busy[wsel] at the clk edge.
  - Issue and write to the same register in the same cycle: set wins, busy stays 1 (new producer).
  - Issue with select >= NUM_REGS is ignored.
  - A write to a register that is not busy is legal; its busy bit stays 0.
- any_busy: combinational OR of the busy vector. Reflects registered state only.
- Reads never stall; consumers gate on rd_busy_*.
- Not part of this block: PC (R15) special-casing and register banking. R15 is an ordinary register here.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding. If weN=1 and wselN == rd_sel_x (in range), rd_data_x returns wdataN in the same cycle. Port 1 has priority over port 0.
  - rd_busy_x is forced to 0 in that case, unless issue_valid targets the same register in that cycle.
  - Forwarding is suppressed while reset=0.
- Undefined: reads return stored contents only. A same-cycle write is not visible until the next cycle.

Decomposition:
- Package reg_file_pkg holds:
  - Default constants: DATA_W_DEF=32, NUM_REGS_DEF=16, ADDR_W_DEF=5.
  - A reg_addr_t typedef of ADDR_W_DEF bits.
  - A function checking that a select is in range.
- One sub-module, reg_scoreboard:
  - Contains the busy vector, set/clear priority logic and any_busy.
  - Ports: clk, reset, issue_valid, issue_sel, we0, wsel0, we1, wsel1, three busy-lookup selects/outputs, any_busy.
- Data storage and read muxing stay in reg_file_mp.

Test Plan:
1. Reset and single write:
   - Hold reset=0 for 2 cycles -> all rd_data_* = 0, any_busy = 0.
   - Release reset; write R3=0xDEADBEEF via port 0 -> next cycle rd_sel_a=3 reads 0xDEADBEEF.
2. Dual-write collision:
   - we0 R5=0x11, we1 R5=0x22 in the same cycle -> R5 reads 0x22.
   - we0 R6=0x33, we1 R7=0x44 -> both stored.
3. Scoreboard:
   - Issue R4 -> rd_busy for R4 = 1, any_busy = 1.
   - Write R4 via port 1 -> busy clears next cycle.
   - Issue R4 and write R4 in the same cycle -> busy remains 1.
4. Out-of-range selects (NUM_REGS=12):
   - Write R13=0x55 -> ignored; R13 reads 0 and R1 is unchanged.
   - Issue R14 -> any_busy stays 0.
5. Reset mid-operation:
   - R2=0x99 and R2 busy; assert reset=0 in the same cycle as we0 R2=0x77 -> R2 reads 0, busy 0.
6. Bypass:
   - With REG_FILE_BYPASS_EN: we1 R8=0xCAFE with rd_sel_b=8 -> rd_data_b = 0xCAFE in that cycle.
   - Without the macro: rd_data_b shows the old value, then 0xCAFE the next cycle.
